// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel tags and left/right pairing-state encoding,
// used by the receive, pairing and transmit stages.
package i2s_pkg;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef logic [0:0] pair_state_t;

  localparam pair_state_t WAIT_LEFT = 1'b0;
  localparam pair_state_t HAVE_LEFT = 1'b1;

  function automatic logic is_left(input logic channel);
    return (channel == CH_LEFT);
  endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// First-word-fall-through frame FIFO. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; fill is tracked apart from the pointers.
module i2s_frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      fill_r;
  logic [WIDTH-1:0] hold_r;
  logic             pop_en_s;
  logic             push_en_s;

  assign empty    = (fill_r == {(AW+1){1'b0}});
  assign full     = (fill_r == FILL_MAX);
  assign fill     = fill_r;
  assign pop_en_s  = pop && !empty;
  assign push_en_s = push && (!full || pop_en_s);

  // Pointer, fill and last-read bookkeeping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      fill_r   <= {(AW+1){1'b0}};
      hold_r   <= {WIDTH{1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        hold_r   <= mem_r[rd_ptr_r];
      end
      case ({push_en_s, pop_en_s})
        2'b10:   fill_r <= fill_r + (AW+1)'(1);
        2'b01:   fill_r <= fill_r - (AW+1)'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Frame storage; contents are only observable once fill says so
  always_ff @(posedge CLK) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Empty FIFO keeps showing the last frame read so the outputs stay stable
  always_comb begin
    if (empty) begin
      head_data = hold_r;
    end else begin
      head_data = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/i2s_frame_pairer.sv
// Pairs consecutive left/right I2S samples into stereo frames, buffers them in
// a FWFT FIFO and flags channel-sequence errors and dropped frames.
module i2s_frame_pairer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int DEPTH        = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [SAMPLE_WIDTH-1:0]   in_sample,
  input  logic                      in_valid,
  input  logic                      in_channel,
  output logic [SAMPLE_WIDTH-1:0]   out_left,
  output logic [SAMPLE_WIDTH-1:0]   out_right,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fill,
  output logic                      overflow,
  output logic                      sync_err,
  input  logic                      clear_flags
);

  localparam int FW = 2 * SAMPLE_WIDTH;

  pair_state_t               state_r;
  pair_state_t               state_nxt_s;
  logic [SAMPLE_WIDTH-1:0]   left_r;
  logic [SAMPLE_WIDTH-1:0]   left_nxt_s;
  logic                      push_s;
  logic                      seq_err_s;
  logic                      pop_s;
  logic                      ovf_s;
  logic                      overflow_r;
  logic                      sync_err_r;
  logic [FW-1:0]             head_s;
  logic                      full_s;
  logic                      empty_s;

  // Pairing decisions for the sample presented this cycle
  always_comb begin
    state_nxt_s = state_r;
    left_nxt_s  = left_r;
    push_s      = 1'b0;
    seq_err_s   = 1'b0;
    if (in_valid) begin
      case (state_r)
        WAIT_LEFT: begin
          if (is_left(in_channel)) begin
            left_nxt_s  = in_sample;
            state_nxt_s = HAVE_LEFT;
          end else begin
            seq_err_s   = 1'b1;
          end
        end
        HAVE_LEFT: begin
          if (in_channel == CH_RIGHT) begin
            push_s      = 1'b1;
            state_nxt_s = WAIT_LEFT;
          end else begin
            left_nxt_s  = in_sample;
            seq_err_s   = 1'b1;
          end
        end
        default: begin
          state_nxt_s = WAIT_LEFT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign pop_s = out_valid && out_ready;
  // A completed frame is lost only when the FIFO is full and nothing leaves
  assign ovf_s = push_s && full_s && !pop_s;

  // Pairing state, left holding register and sticky flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= WAIT_LEFT;
      left_r     <= {SAMPLE_WIDTH{1'b0}};
      overflow_r <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      left_r  <= left_nxt_s;
      if (ovf_s) begin
        overflow_r <= 1'b1;
      end else if (clear_flags) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (seq_err_s) begin
        sync_err_r <= 1'b1;
      end else if (clear_flags) begin
        sync_err_r <= 1'b0;
      end else begin
        sync_err_r <= sync_err_r;
      end
    end
  end

  i2s_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_s),
    .push_data ({left_r, in_sample}),
    .pop       (pop_s),
    .head_data (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .fill      (fill)
  );

  assign out_valid = !empty_s;
  assign out_left  = head_s[FW-1:SAMPLE_WIDTH];
  assign out_right = head_s[SAMPLE_WIDTH-1:0];
  assign overflow  = overflow_r;
  assign sync_err  = sync_err_r;

endmodule
